// File: rtl/prior_scanner_pkg.sv
// Shared types for the priority scanner: FSM states and scan-order encoding.
package prior_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } order_e;

endpackage

// File: rtl/prior_find.sv
// Combinational highest-set-bit finder; idx is the 1-based position, 0 when no bit is set.
module prior_find #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [$clog2(DATA_WIDTH):0] idx
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;

  // Later (higher) set bits overwrite earlier ones, so the highest wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data_in[i]) idx = IW'(i + 1);
    end
  end

endmodule

// File: rtl/prior_scanner.sv
// Priority scanner: accepts a vector and emits one beat per set bit, in MSB- or LSB-first order.
//   state | meaning
//   IDLE  | no vector held, in_ready = 1
//   SCAN  | beats of the held vector are being presented on out_*
module prior_scanner
  import prior_scanner_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_msb_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_idx,
  output logic                   out_last,
  output logic                   out_empty,
  output logic [INDEX_WIDTH-1:0] out_seq
);

  localparam int FW = $clog2(DATA_WIDTH) + 1;

  state_e                 state_q, state_d;
  order_e                 order_q, order_d;
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
  logic [INDEX_WIDTH-1:0] seq_q, seq_d;

  logic [DATA_WIDTH-1:0]  rem_rev;
  logic [FW-1:0]          idx_msb, idx_rev, idx_lsb, idx_sel;
  logic                   accept, beat;

  always_comb begin
    rem_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) rem_rev[i] = rem_q[DATA_WIDTH-1-i];
  end

  prior_find #(.DATA_WIDTH(DATA_WIDTH)) u_find_msb (
    .data_in (rem_q),
    .idx     (idx_msb)
  );

  prior_find #(.DATA_WIDTH(DATA_WIDTH)) u_find_lsb (
    .data_in (rem_rev),
    .idx     (idx_rev)
  );

  // Highest bit of the reversed vector maps back to the lowest bit of rem.
  assign idx_lsb = (idx_rev == '0) ? '0 : FW'(DATA_WIDTH + 1) - idx_rev;
  assign idx_sel = (order_q == ORDER_MSB) ? idx_msb : idx_lsb;

  assign out_valid = (state_q == SCAN);
  assign out_last  = ((rem_q & (rem_q - DATA_WIDTH'(1))) == '0);
  assign out_empty = out_valid && (rem_q == '0);
  assign out_idx   = INDEX_WIDTH'(idx_sel);
  assign out_seq   = seq_q;
  assign in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);

  assign accept = in_valid && in_ready;
  assign beat   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    if (beat) begin
      if (out_last) begin
        state_d = IDLE;
        rem_d   = '0;
        seq_d   = '0;
      end else begin
        rem_d = rem_q & ~(DATA_WIDTH'(1) << (idx_sel - FW'(1)));
        seq_d = seq_q + INDEX_WIDTH'(1);
      end
    end
    // A new vector overrides the end-of-vector return to IDLE, giving back-to-back scans.
    if (accept) begin
      state_d = SCAN;
      order_d = order_e'(in_msb_first);
      rem_d   = in_data;
      seq_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      order_q <= ORDER_LSB;
      rem_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
    end
  end

endmodule

// File: tb/tb_prior_scanner.sv
// Self-checking bench for prior_scanner (DATA_WIDTH = 8) against a beat-list reference model.
module tb_prior_scanner;

  localparam int DW = 8;
  localparam int IW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_msb_first;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_empty;
  logic [IW-1:0] out_seq;

  typedef struct {
    int idx;
    int last;
    int empty;
    int seq;
  } beat_t;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats_seen = 0;
  logic  rdy_rand = 1'b0;
  logic  rdy_val  = 1'b1;

  prior_scanner #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_empty    (out_empty),
    .out_seq      (out_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list the set bit positions in scan order; an all-zero vector yields one empty beat.
  task automatic push_expected(input logic [DW-1:0] d, input logic msb);
    int    pos[$];
    beat_t b;
    if (d == '0) begin
      b.idx = 0; b.last = 1; b.empty = 1; b.seq = 0;
      q.push_back(b);
    end else begin
      for (int i = 0; i < DW; i++) begin
        if (d[i]) begin
          if (msb) pos.push_front(i);
          else     pos.push_back(i);
        end
      end
      foreach (pos[k]) begin
        b.idx = pos[k] + 1; b.last = (k == pos.size() - 1); b.empty = 0; b.seq = k;
        q.push_back(b);
      end
    end
  endtask

  always @(posedge clk) begin
    #1 out_ready = rdy_rand ? (($urandom % 4) != 0) : rdy_val;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
      check("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        check("out_idx", out_idx, q[0].idx);
        check("out_last", out_last, q[0].last);
        check("out_empty", out_empty, q[0].empty);
        check("out_seq", out_seq, q[0].seq);
        if (out_ready) begin
          void'(q.pop_front());
          beats_seen++;
        end
      end
      if (in_valid && in_ready) push_expected(in_data, in_msb_first);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic msb);
    int acc = 0;
    in_valid = 1'b1; in_data = d; in_msb_first = msb;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
    end
    check("accept", acc, 1);
  endtask

  task automatic drop();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 1);
    check({tag, "_empty"}, out_empty, 0);
    check({tag, "_seq"}, out_seq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0;
    #3 check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    send(8'hA5, 1'b0); drop(); drain();
    send(8'hA5, 1'b1); drop(); drain();
    send(8'h00, 1'b0); drop(); drain();

    rdy_val = 1'b0;
    @(posedge clk); #2;
    send(8'h81, 1'b0); drop();
    repeat (3) @(posedge clk);
    check("hold_idx", out_idx, 1);
    check("hold_valid", out_valid, 1);
    rdy_val = 1'b1;
    drain();

    send(8'h01, 1'b0); send(8'h80, 1'b0); drop(); drain();

    base = beats_seen;
    send(8'hFF, 1'b0); drop();
    for (int c = 0; c < 50 && beats_seen < base + 2; c++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    q.delete();
    @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drain();

    rdy_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      d = DW'($urandom);
      if (($urandom % 8) == 0) d = '0;
      else if (($urandom % 8) == 0) d = '1;
      send(d, 1'($urandom % 2));
      if (($urandom % 3) == 0) begin
        drop();
        repeat ($urandom % 6) @(posedge clk);
        #1;
      end
    end
    drop();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prior_scanner.md
PRIOR_SCANNER -- requirements
Module: prior_scanner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the scanned vector, legal range 2..1024.
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(DATA_WIDTH)+1: width of the 1-based index.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a vector is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the vector this cycle.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: the vector to scan.
REQ-008 SHALL have port in_msb_first, input, 1 bit: scan order, 1 = MSB first, 0 = LSB first; captured with in_data.
REQ-009 SHALL have port out_valid, output, 1 bit: an index beat is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 SHALL have port out_idx, output, INDEX_WIDTH bits: bit position + 1; 0 means no bit set.
REQ-012 SHALL have port out_last, output, 1 bit: final beat of the current vector.
REQ-013 SHALL have port out_empty, output, 1 bit: the captured vector was all zero.
REQ-014 SHALL have port out_seq, output, INDEX_WIDTH bits: 0-based beat number within the vector.

Function
REQ-015 SHALL implement two states: IDLE and SCAN.
REQ-016 SHALL drive in_ready = 1 in IDLE, and in SCAN only when out_valid & out_ready & out_last.
REQ-017 SHALL, on in_valid & in_ready, register in_data into the remaining-vector register (rem), register in_msb_first, clear the sequence counter, and enter or stay in SCAN.
REQ-018 SHALL assert out_valid exactly in SCAN; the first beat appears the cycle after acceptance (latency 1).
REQ-019 SHALL drive out_idx combinationally from rem: highest set bit + 1 if msb_first, else lowest set bit + 1; 0 if rem == 0.
REQ-020 SHALL drive out_last = 1 when rem has at most one bit set.
REQ-021 SHALL drive out_empty = 1 only when rem == 0 in SCAN; such a vector produces exactly one beat with out_idx = 0, out_last = 1, out_seq = 0.
REQ-022 SHALL, on out_valid & out_ready & ~out_last, clear the reported bit in rem and increment out_seq.
REQ-023 SHALL, on out_valid & out_ready & out_last without a new acceptance, return to IDLE.
REQ-024 SHALL, when the last beat is accepted and a new vector is accepted in the same cycle, load the new vector and remain in SCAN with no bubble.
REQ-025 SHALL hold out_idx, out_last, out_empty and out_seq stable while out_valid & ~out_ready.
REQ-026 SHALL emit popcount(in_data) beats for a nonzero vector, with out_seq running 0 .. popcount-1.
REQ-027 SHALL NOT wrap out_seq; its maximum value is DATA_WIDTH-1.

Reset
REQ-028 SHALL, on rst_n low, immediately force state = IDLE, rem = 0, seq = 0 and msb_first = 0, including during a scan.
REQ-029 SHALL drive these output values during reset: out_valid = 0, in_ready = 1, out_idx = 0, out_last = 1, out_empty = 0, out_seq = 0.
REQ-030 SHALL discard a partially scanned vector on reset, with no further beats after reset deassertion.

Structure
REQ-031 SHALL place the state enum (IDLE, SCAN) and the scan-order encoding in package prior_scanner_pkg.
REQ-032 SHALL instantiate one combinational sub-module, prior_find, twice: once on rem for MSB-first order and once on bit-reversed rem for LSB-first order.
REQ-033 SHALL give prior_find the parameter DATA_WIDTH, input data_in, and output idx (1-based, 0 = none).
REQ-034 SHALL register only state, rem, msb_first and seq; all outputs are decoded from these.

Verification (DATA_WIDTH = 8)
REQ-035 SHALL cover: in_data = 8'b1010_0101, LSB first, out_ready = 1 -> out_idx 1, 3, 6, 8 on consecutive cycles; out_seq 0..3; out_last only with 8.
REQ-036 SHALL cover: the same vector MSB first -> out_idx 8, 6, 3, 1; out_last only with 1.
REQ-037 SHALL cover: in_data = 0 -> one beat with out_idx = 0, out_empty = 1, out_last = 1; then IDLE.
REQ-038 SHALL cover: 8'h81 with out_ready held low for 3 cycles on the first beat -> out_idx = 1 held stable for 3 cycles, then 8 follows.
REQ-039 SHALL cover: in_valid held high with 8'h01 then 8'h80 -> beats idx 1 then idx 8 on adjacent cycles, with in_ready = 1 on the last-beat cycle.
REQ-040 SHALL cover: 8'hFF with rst_n pulsed low after 2 beats -> out_valid = 0 immediately, in_ready = 1, and no stale beats after release.
